// File: rtl/arm_barrel_shifter_pkg.sv
// arm_shift_pkg: shared shift-type encoding, datapath widths and bit-reversal helper.
package arm_shift_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // Left shifts reuse the right-shift network by mirroring the word on both sides.
    function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
        for (int j = 0; j < DATA_W; j++) bit_rev[j] = v[DATA_W-1-j];
    endfunction

endpackage

// File: rtl/arm_barrel_shifter_if.sv
// arm_barrel_shifter_if: operand/result bundle between the operand source and the shifter.
interface arm_barrel_shifter_if;
    import arm_shift_pkg::*;

    logic               in_valid;
    logic [DATA_W-1:0]  data_in;
    logic [SHAMT_W-1:0] shamt;
    shift_t             sh_type;
    logic               carry_in;
    logic               out_valid;
    logic [DATA_W-1:0]  data_out;
    logic               carry_out;

    modport master (
        output in_valid, data_in, shamt, sh_type, carry_in,
        input  out_valid, data_out, carry_out
    );

    modport slave (
        input  in_valid, data_in, shamt, sh_type, carry_in,
        output out_valid, data_out, carry_out
    );

endinterface

// File: rtl/arm_barrel_shifter_core.sv
// arm_shift_core: combinational 5-stage log barrel shifter with ARM carry-out; ROR #0 becomes RRX when SHIFTER_RRX_EN is defined.
module arm_shift_core
    import arm_shift_pkg::*;
(
    input  logic [DATA_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_t             sh_type,
    input  logic               carry_in,
    output logic [DATA_W-1:0]  data_out,
    output logic               carry_out
);

    logic               lsl;
    logic               rot;
    logic               fill;
    logic [DATA_W-1:0]  src;
    logic [DATA_W-1:0]  shifted;
    logic [DATA_W-1:0]  ror0_res;
    logic               ror0_c;
    logic [DATA_W-1:0]  st [0:SHAMT_W];

    assign lsl  = sh_type == SH_LSL;
    assign rot  = sh_type == SH_ROR;
    assign fill = sh_type == SH_ASR && data_in[DATA_W-1];
    assign src  = lsl ? bit_rev(data_in) : data_in;

    assign st[0] = src;

    // Stage i moves the word right by 2**i, filling with wrapped bits (ROR) or the fill bit.
    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int K = 1 << i;
        assign st[i+1] = shamt[i] ? {rot ? st[i][K-1:0] : {K{fill}}, st[i][DATA_W-1:K]} : st[i];
    end

    assign shifted = lsl ? bit_rev(st[SHAMT_W]) : st[SHAMT_W];

`ifdef SHIFTER_RRX_EN
    assign ror0_res = {carry_in, data_in[DATA_W-1:1]};
    assign ror0_c   = data_in[0];
`else
    assign ror0_res = data_in;
    assign ror0_c   = carry_in;
`endif

    // Non-zero amounts take the network output; the last bit shifted out is src[n-1] in mirrored space.
    // Zero amounts select the ARMv4 special encodings (LSL #0, LSR #32, ASR #32, ROR #0/RRX).
    always_comb begin
        data_out  = shamt != '0       ? shifted :
                    lsl               ? data_in :
                    sh_type == SH_LSR ? '0 :
                    sh_type == SH_ASR ? {DATA_W{data_in[DATA_W-1]}} : ror0_res;
        carry_out = shamt != '0 ? src[shamt - 1'b1] :
                    lsl         ? carry_in :
                    rot         ? ror0_c : data_in[DATA_W-1];
    end

endmodule

// File: rtl/arm_barrel_shifter.sv
// arm_barrel_shifter: registered ARM operand-2 shifter, one-cycle latency; optional RRX via SHIFTER_RRX_EN.
module arm_barrel_shifter
    import arm_shift_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    arm_barrel_shifter_if.slave  bus
);

    logic [DATA_W-1:0] res;
    logic              res_c;

    arm_shift_core u_core (
        .data_in   (bus.data_in),
        .shamt     (bus.shamt),
        .sh_type   (bus.sh_type),
        .carry_in  (bus.carry_in),
        .data_out  (res),
        .carry_out (res_c)
    );

    // Valid follows the input every cycle; result registers load only on valid input and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.carry_out <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.data_out  <= res;
                bus.carry_out <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_arm_barrel_shifter.sv
// tb_arm_barrel_shifter: directed plus randomized checks of arm_barrel_shifter against an arithmetic reference model.
module tb_arm_barrel_shifter;
    import arm_shift_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   failed = 0;

    logic        exp_v = 1'b0;
    logic        exp_c = 1'b0;
    logic [31:0] exp_d = '0;

    arm_barrel_shifter_if bus();

    arm_barrel_shifter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: shifts done on 64-bit words so the bit just past the result is the carry.
    function automatic logic [32:0] ref_shift(input logic [31:0] d, input logic [4:0] n,
                                              input logic [1:0] t, input logic c);
        logic [63:0]        w;
        logic signed [63:0] s;
        int                 nn;
        nn = (n == 0) ? 32 : int'(n);
        case (t)
            2'b00: begin
                if (n == 0) return {c, d};
                w = {32'b0, d} << n;
                return {w[32], w[31:0]};
            end
            2'b01: begin
                w = {d, 32'b0} >> nn;
                return {w[31], w[63:32]};
            end
            2'b10: begin
                s = {d, 32'b0};
                s = s >>> nn;
                return {s[31], s[63:32]};
            end
            default: begin
`ifdef SHIFTER_RRX_EN
                if (n == 0) return {d[0], c, d[31:1]};
`else
                if (n == 0) return {c, d};
`endif
                w = {d, d} >> n;
                return {w[31], w[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed v/c/d=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] n,
                         input logic [1:0] t, input logic c);
        logic [32:0] r;
        bus.in_valid = v;
        bus.data_in  = d;
        bus.shamt    = n;
        bus.sh_type  = shift_t'(t);
        bus.carry_in = c;
        r = ref_shift(d, n, t, c);
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) {exp_c, exp_d} = r;
    endtask

    function automatic logic [33:0] obs_now();
        return {bus.out_valid, bus.carry_out, bus.data_out};
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.shamt    = '0;
        bus.sh_type  = SH_LSL;
        bus.carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs_now(), 34'h0);
        reset = 1'b0;

        drive(1, 32'h0000_0007, 2, 2'b00, 0);
        check("lsl2", obs_now(), {1'b1, 1'b0, 32'h0000_001C});
        drive(1, 32'h8000_0001, 1, 2'b00, 0);
        check("lsl1_carry", obs_now(), {1'b1, 1'b1, 32'h0000_0002});
        drive(1, 32'h1357_9BDF, 0, 2'b00, 1);
        check("lsl0", obs_now(), {1'b1, 1'b1, 32'h1357_9BDF});
        drive(1, 32'h8000_0000, 0, 2'b01, 0);
        check("lsr32", obs_now(), {1'b1, 1'b1, 32'h0000_0000});
        drive(1, 32'h8000_00F0, 4, 2'b10, 0);
        check("asr4", obs_now(), {1'b1, 1'b0, 32'hF800_000F});
        drive(1, 32'h8000_0000, 0, 2'b10, 0);
        check("asr32", obs_now(), {1'b1, 1'b1, 32'hFFFF_FFFF});
        drive(1, 32'h1234_5678, 8, 2'b11, 1);
        check("ror8", obs_now(), {1'b1, 1'b0, 32'h7812_3456});
        drive(1, 32'h0000_0003, 0, 2'b11, 1);
`ifdef SHIFTER_RRX_EN
        check("rrx", obs_now(), {1'b1, 1'b1, 32'h8000_0001});
`else
        check("ror0", obs_now(), {1'b1, 1'b1, 32'h0000_0003});
`endif
        drive(1, 32'hFFFF_FFFF, 31, 2'b00, 0);
        check("lsl31", obs_now(), {1'b1, 1'b1, 32'h8000_0000});
        drive(1, 32'h4000_0000, 31, 2'b01, 1);
        check("lsr31", obs_now(), {1'b1, 1'b1, 32'h0000_0000});

        drive(1, 32'hA5A5_0001, 3, 2'b00, 0);
        check("b2b_1", obs_now(), {exp_v, exp_c, exp_d});
        drive(1, 32'h8765_4321, 5, 2'b10, 0);
        check("b2b_2", obs_now(), {exp_v, exp_c, exp_d});
        drive(1, 32'h0F0F_0F0F, 12, 2'b11, 0);
        check("b2b_3", obs_now(), {exp_v, exp_c, exp_d});
        drive(0, 32'hDEAD_BEEF, 7, 2'b01, 1);
        check("hold", obs_now(), {1'b0, exp_c, exp_d});
        drive(0, 32'h1111_1111, 1, 2'b00, 1);
        check("hold2", obs_now(), {1'b0, exp_c, exp_d});

        for (int k = 0; k < 300; k++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, 5'($urandom), 2'($urandom), 1'($urandom));
            check("random", obs_now(), {exp_v, exp_c, exp_d});
        end

        drive(1, 32'hCAFE_F00D, 9, 2'b01, 0);
        check("pre_reset", obs_now(), {exp_v, exp_c, exp_d});
        #2 reset = 1'b1;
        #1 check("async_reset", obs_now(), 34'h0);
        #1 reset = 1'b0;
        exp_v = 0; exp_c = 0; exp_d = '0;
        drive(1, 32'h0000_00F1, 4, 2'b11, 0);
        check("post_reset", obs_now(), {1'b1, 1'b0, 32'h1000_000F});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
